// File: rtl/fir_tap_sequencer.sv
// Control FSM for a serial single-MAC FIR: one chain shift per sample, then a 0..P_TAPS-1 tap sweep.
// Optional saturating refused-request counter enabled by defining SEQ_DROP_CNT_EN.
module fir_tap_sequencer #(
    parameter int P_TAPS  = 10,
    parameter int P_SEL_W = 4
) (
    input  logic               iClk,
    input  logic               iRsn,
    input  logic               iInValid,
    output logic               oInReady,
    output logic               oEnDelay,
    output logic [P_SEL_W-1:0] oInSel,
    output logic               oMacClr,
    output logic               oMacEn,
    output logic               oMacLast,
    output logic               oOutValid,
    input  logic               iOutReady,
    output logic [7:0]         oDropCnt
);

    typedef enum logic [1:0] {IDLE, SHIFT, SWEEP, DONE} state_t;

    localparam logic [P_SEL_W-1:0] LAST_SEL = P_SEL_W'(P_TAPS - 1);

    state_t             state_reg, state_next;
    logic [P_SEL_W-1:0] cnt_reg, cnt_next;

    logic               en_delay_reg, en_delay_next;
    logic [P_SEL_W-1:0] sel_reg, sel_next;
    logic               mac_clr_reg, mac_clr_next;
    logic               mac_en_reg, mac_en_next;
    logic               mac_last_reg, mac_last_next;
    logic               out_valid_reg, out_valid_next;
    logic               sweep_next;

    // Outputs are registered from the next-state decode so they line up with the state they describe.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (iInValid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                state_next = SWEEP;
                cnt_next   = '0;
            end
            SWEEP: begin
                if (cnt_reg == LAST_SEL) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + P_SEL_W'(1);
                end
            end
            DONE: begin
                if (iOutReady) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        sweep_next     = (state_next == SWEEP);
        en_delay_next  = (state_next == SHIFT);
        sel_next       = sweep_next ? cnt_next : '0;
        mac_en_next    = sweep_next;
        mac_clr_next   = sweep_next && (cnt_next == '0);
        mac_last_next  = sweep_next && (cnt_next == LAST_SEL);
        out_valid_next = (state_next == DONE);
    end

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            en_delay_reg  <= 1'b0;
            sel_reg       <= '0;
            mac_clr_reg   <= 1'b0;
            mac_en_reg    <= 1'b0;
            mac_last_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            en_delay_reg  <= en_delay_next;
            sel_reg       <= sel_next;
            mac_clr_reg   <= mac_clr_next;
            mac_en_reg    <= mac_en_next;
            mac_last_reg  <= mac_last_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign oInReady  = (state_reg == IDLE);
    assign oEnDelay  = en_delay_reg;
    assign oInSel    = sel_reg;
    assign oMacClr   = mac_clr_reg;
    assign oMacEn    = mac_en_reg;
    assign oMacLast  = mac_last_reg;
    assign oOutValid = out_valid_reg;

`ifdef SEQ_DROP_CNT_EN
    logic [7:0] drop_cnt_reg;

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            drop_cnt_reg <= 8'd0;
        end else if (iInValid && (state_reg != IDLE) && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end

    assign oDropCnt = drop_cnt_reg;
`else
    assign oDropCnt = 8'd0;
`endif

endmodule
